// File: rtl/pwm.sv
// Fixed-frequency PWM generator with H-bridge direction outputs.
// Duty and direction are captured into shadow registers at each period
// start so mid-period input changes never produce partial or glitched periods.
module pwm #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned PWM_FREQ  = 20_000,
    parameter int unsigned COUNTER_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [COUNTER_W-1:0] duty_cycle,
    input  logic                 direction,
    output logic                 ina,
    output logic                 inb,
    output logic                 pwm_out
);

    localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int unsigned CNT_W  = $clog2(PERIOD);
    localparam int unsigned PROD_W = COUNTER_W + CNT_W;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [PROD_W-1:0] PERIOD_P = PROD_W'(PERIOD);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  thr_q, thr_d;
    logic              dir_q, dir_d;
    logic              pwm_q, pwm_d;
    logic              ina_q, ina_d;
    logic              inb_q, inb_d;

    logic [PROD_W-1:0] prod;
    logic [CNT_W-1:0]  thr;
    logic [CNT_W-1:0]  thr_used;
    logic              dir_used;
    logic              start;

    // Threshold from duty word, next-state for counter, shadows and outputs
    always_comb begin
        prod     = PROD_W'(duty_cycle) * PERIOD_P;
        thr      = CNT_W'(prod >> COUNTER_W);
        start    = (cnt_q == '0);
        // At a period start the freshly sampled inputs take effect on the same edge
        thr_used = start ? thr : thr_q;
        dir_used = start ? direction : dir_q;

        cnt_d = '0;
        thr_d = thr_q;
        dir_d = dir_q;
        pwm_d = 1'b0;
        ina_d = 1'b0;
        inb_d = 1'b0;

        if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            if (start) begin
                thr_d = thr;
                dir_d = direction;
            end
            pwm_d = (cnt_q < thr_used);
            ina_d = ~dir_used;
            inb_d = dir_used;
        end
    end

    // State and registered outputs, asynchronously cleared to coast
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            thr_q <= '0;
            dir_q <= 1'b0;
            pwm_q <= 1'b0;
            ina_q <= 1'b0;
            inb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            thr_q <= thr_d;
            dir_q <= dir_d;
            pwm_q <= pwm_d;
            ina_q <= ina_d;
            inb_q <= inb_d;
        end
    end

    assign pwm_out = pwm_q;
    assign ina     = ina_q;
    assign inb     = inb_q;

endmodule

// File: tb/tb_pwm.sv
// Scoreboard bench for pwm: stimulus pushes hand-computed output segments
// (value of {pwm_out,ina,inb} and run length in cycles); the monitor
// run-length encodes the DUT outputs and checks each completed run.
module tb_pwm;

    localparam int unsigned COUNTER_W = 12;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [COUNTER_W-1:0] duty_cycle;
    logic                 direction;
    logic                 ina;
    logic                 inb;
    logic                 pwm_out;

    int checks = 0;
    int errors = 0;
    bit both_hi = 1'b0;

    typedef struct packed {
        logic [2:0]  val;   // {pwm_out, ina, inb}
        logic [15:0] len;
        logic [7:0]  id;
    } seg_t;

    seg_t exp_q[$];

    always #5 clk = ~clk;

    pwm #(
        .CLK_FREQ (50_000_000),
        .PWM_FREQ (20_000),
        .COUNTER_W(COUNTER_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .duty_cycle(duty_cycle),
        .direction (direction),
        .ina       (ina),
        .inb       (inb),
        .pwm_out   (pwm_out)
    );

    task automatic push(input int unsigned id, input logic [2:0] val, input int unsigned len);
        seg_t s;
        s.val = val;
        s.len = 16'(len);
        s.id  = 8'(id);
        exp_q.push_back(s);
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: sample after each rising edge, close a run when the outputs change
    initial begin
        bit          started;
        logic [2:0]  cur;
        logic [2:0]  s;
        int unsigned run;
        seg_t        e;
        started = 1'b0;
        run     = 0;
        cur     = '0;
        forever begin
            @(posedge clk);
            #1;
            s = {pwm_out, ina, inb};
            if (ina && inb) both_hi = 1'b1;
            if (!started) begin
                cur     = s;
                run     = 1;
                started = 1'b1;
            end else if (s == cur) begin
                run++;
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL seg_extra: got val=%b len=%0d, required no further segment", cur, run);
                end else begin
                    e = exp_q.pop_front();
                    if (e.val !== cur || int'(e.len) != run) begin
                        errors++;
                        if (errors <= 20)
                            $display("FAIL seg%0d: got val=%b len=%0d, required val=%b len=%0d",
                                     e.id, cur, run, e.val, e.len);
                    end
                end
                cur = s;
                run = 1;
            end
        end
    end

    // Stimulus: directed vectors, each pushing the output runs it determines
    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        duty_cycle = 12'd4095;
        direction  = 1'b0;

        // 5 reset cycles plus 2 disabled periods, then first edge with enable high
        push(1, 3'b000, 5 + 5000);
        cycles(5);
        reset = 1'b0;
        cycles(5000);

        // N0: CW, duty 1024 -> 625 high / 1875 low
        enable     = 1'b1;
        duty_cycle = 12'd1024;
        direction  = 1'b0;
        push(2, 3'b110, 625);
        push(3, 3'b010, 1875);
        push(4, 3'b110, 625);
        push(5, 3'b010, 1875);
        push(6, 3'b110, 625);   // third period unaffected by the mid-period change
        push(7, 3'b010, 1875);

        // N0+5100 (cnt=100): CCW, duty 3072 -> 1875 high / 625 low from next period
        cycles(5100);
        duty_cycle = 12'd3072;
        direction  = 1'b1;
        push(8, 3'b101, 1875);
        push(9, 3'b001, 625);
        push(10, 3'b101, 1875);

        // N0+10050: duty 0 -> low 625 of current period merges with a full zero period
        cycles(4950);
        duty_cycle = 12'd0;
        push(11, 3'b001, 625 + 2500);

        // N0+12510: duty 4095 -> 2499 high / 1 low
        cycles(2460);
        duty_cycle = 12'd4095;
        push(12, 3'b101, 2499);
        push(13, 3'b001, 1);

        // N0+17500: direction change exactly at cnt==0 applies to that period
        cycles(4990);
        direction = 1'b0;
        push(14, 3'b110, 2499);
        push(15, 3'b010, 1);

        // N0+20300: enable drops 300 cycles into a period
        cycles(2800);
        enable = 1'b0;
        push(16, 3'b110, 300);
        push(17, 3'b000, 200);

        // N1 = N0+20500: re-enable CCW duty 1024, full period from cnt=0
        cycles(200);
        enable     = 1'b1;
        duty_cycle = 12'd1024;
        direction  = 1'b1;
        push(18, 3'b101, 100);
        push(19, 3'b000, 2);

        // Async reset 100 cycles in: outputs must drop without a clock edge
        cycles(100);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({pwm_out, ina, inb} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got val=%b, required val=000", {pwm_out, ina, inb});
        end
        cycles(2);
        reset = 1'b0;
        push(20, 3'b101, 625);
        push(21, 3'b001, 1875);

        // One full period after reset release, reset again to close the last run
        cycles(2500);
        #2;
        reset = 1'b1;
        cycles(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL seg_missing: got %0d segments outstanding, required 0", exp_q.size());
        end
        checks++;
        if (both_hi) begin
            errors++;
            $display("FAIL ina_inb_exclusive: got both high at some cycle, required never");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
